// File: rtl/hippo_fetch_unit_pkg.sv
// hippo_fetch_unit_pkg: shared types and constants for the fetch stage
package hippo_fetch_unit_pkg;
  typedef logic [31:0] addr_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    addr_t       pc;
    logic [31:0] instr;
    logic        fault;
    logic        filled;
  } fetch_slot_t;
endpackage

// File: rtl/hippo_fetch_unit_slot_buffer.sv
// hippo_fetch_unit_slot_buffer: circular slot array with alloc/fill/read pointers and flush
module hippo_fetch_unit_slot_buffer
  import hippo_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc,
  input  addr_t       alloc_pc,
  input  logic        fill,
  input  logic [31:0] fill_instr,
  input  logic        fill_err,
  input  logic        pop,
  output logic        full,
  output logic [PW:0] unfilled,
  output fetch_slot_t head
);
  fetch_slot_t slots [DEPTH];
  logic [PW:0] alloc_ptr, fill_ptr, rd_ptr;
  assign full = (alloc_ptr - rd_ptr) == (PW+1)'(DEPTH);
  assign unfilled = alloc_ptr - fill_ptr;
  assign head = slots[rd_ptr[PW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        slots[alloc_ptr[PW-1:0]].pc <= alloc_pc;
        slots[alloc_ptr[PW-1:0]].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        slots[fill_ptr[PW-1:0]].instr <= fill_instr;
        slots[fill_ptr[PW-1:0]].fault <= fill_err;
        slots[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        slots[rd_ptr[PW-1:0]].filled <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/hippo_fetch_unit.sv
// hippo_fetch_unit: in-order instruction fetch with slot buffer, redirect flush and stale-response drop
module hippo_fetch_unit
  import hippo_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fetch_fault,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH*2) + 1;
  addr_t fetch_pc;
  logic [DW-1:0] drop_cnt;
  logic full, req_fire, rsp_fill, pop;
  logic [PW:0] unfilled;
  fetch_slot_t head;
  assign o_imem_req_valid = i_reset & ~full & ~i_redirect_valid;
  assign o_imem_addr = fetch_pc;
  assign req_fire = o_imem_req_valid & i_imem_req_ready;
  assign rsp_fill = i_imem_rsp_valid & (drop_cnt == '0) & ~i_redirect_valid;
  assign o_instr_valid = head.filled;
  assign pop = head.filled & i_instr_ready;
  assign o_instr = (head.filled & ~head.fault) ? head.instr : NOP_INSTR;
  assign o_pc = head.pc;
  assign o_fetch_fault = head.filled & head.fault;
  hippo_fetch_unit_slot_buffer #(.DEPTH(DEPTH)) u_slots (
    .clk(i_clk),
    .rst_n(i_reset),
    .flush(i_redirect_valid),
    .alloc(req_fire),
    .alloc_pc(fetch_pc),
    .fill(rsp_fill),
    .fill_instr(i_imem_rsp_data),
    .fill_err(i_imem_rsp_err),
    .pop(pop),
    .full(full),
    .unfilled(unfilled),
    .head(head)
  );
  // a same-cycle response is either a pending drop or one of the unfilled slots, so it is subtracted once
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      fetch_pc <= i_redirect_valid ? (i_redirect_pc & ~32'h3) : req_fire ? fetch_pc + 32'd4 : fetch_pc;
      drop_cnt <= i_redirect_valid ? drop_cnt + DW'(unfilled) - DW'(i_imem_rsp_valid)
                                   : drop_cnt - DW'(i_imem_rsp_valid && drop_cnt != '0);
    end
  end
endmodule

// File: tb/tb_hippo_fetch_unit.sv
// tb_hippo_fetch_unit: random and directed fetch traffic checked against an epoch-tagged scoreboard
module tb_hippo_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic i_clk = 1'b0;
  logic i_reset;
  logic o_imem_req_valid, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_err;
  logic [31:0] o_imem_addr, i_imem_rsp_data, o_instr, o_pc, i_redirect_pc;
  logic o_instr_valid, i_instr_ready, o_fetch_fault, i_redirect_valid;
  hippo_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr(o_imem_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data),
    .i_imem_rsp_err(i_imem_rsp_err),
    .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready),
    .o_instr(o_instr),
    .o_pc(o_pc),
    .o_fetch_fault(o_fetch_fault),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic fault;} ent_t;
  req_t pend[$];
  ent_t exp_q[$];
  int total = 0, bad = 0;
  int epoch = 0, arrived = 0, cyc = 0, last_due = 0, fires = 0;
  int lat_lo = 1, lat_hi = 1;
  int f0;
  logic [31:0] m_pc = 32'h0;
  logic err_on = 1'b0, rnd_err = 1'b0;
  logic [31:0] err_addr = 32'h0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9617;
  endfunction
  function automatic logic mem_err(input logic [31:0] a);
    return (err_on && a == err_addr) || (rnd_err && a[7:2] == 6'd13);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    arrived = 0;
    epoch++;
    m_pc = 32'h0;
    last_due = 0;
  endtask
  task automatic step(input logic rq, input logic ir, input logic rd, input logic [31:0] tgt);
    logic exp_req, exp_v, rsp;
    req_t r;
    int d;
    @(negedge i_clk);
    i_imem_req_ready = rq;
    i_instr_ready = ir;
    i_redirect_valid = rd;
    i_redirect_pc = tgt;
    rsp = pend.size() > 0 && pend[0].due <= cyc;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data = rsp ? word(pend[0].addr) : $urandom;
    i_imem_rsp_err = rsp ? mem_err(pend[0].addr) : 1'($urandom);
    #1;
    exp_req = !rd && exp_q.size() < DEPTH;
    exp_v = arrived > 0;
    chk("req_valid", 32'(o_imem_req_valid), 32'(exp_req));
    if (exp_req) chk("imem_addr", o_imem_addr, m_pc);
    chk("instr_valid", 32'(o_instr_valid), 32'(exp_v));
    if (exp_v) begin
      chk("pc", o_pc, exp_q[0].pc);
      chk("instr", o_instr, exp_q[0].instr);
      chk("fault", 32'(o_fetch_fault), 32'(exp_q[0].fault));
    end
    if (rsp) begin
      r = pend.pop_front();
      if (!rd && r.epoch == epoch) arrived++;
    end
    if (!rd && exp_v && ir) begin
      void'(exp_q.pop_front());
      arrived--;
    end
    if (exp_req && rq) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d < last_due) d = last_due;
      last_due = d;
      pend.push_back('{m_pc, epoch, d});
      exp_q.push_back('{m_pc, mem_err(m_pc) ? NOP : word(m_pc), mem_err(m_pc)});
      m_pc += 32'd4;
      fires++;
    end
    if (rd) begin
      exp_q.delete();
      arrived = 0;
      epoch++;
      m_pc = tgt & ~32'h3;
    end
    cyc++;
  endtask
  task automatic check_reset_outputs();
    chk("rst_req_valid", 32'(o_imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(o_instr_valid), 32'h0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_fault", 32'(o_fetch_fault), 32'h0);
  endtask
  initial begin
    i_reset = 1'b0;
    i_imem_req_ready = 1'b0;
    i_instr_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = 32'h0;
    i_imem_rsp_err = 1'b0;
    #3;
    check_reset_outputs();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    // steady streaming, single-cycle memory
    repeat (12) step(1, 1, 0, 0);
    // decode stalled, 3-cycle memory: only DEPTH requests, then one per pop
    lat_lo = 3;
    lat_hi = 3;
    step(1, 0, 1, 32'h200);
    f0 = fires;
    repeat (8) step(1, 0, 0, 0);
    chk("full_req_count", fires - f0, DEPTH);
    step(1, 1, 0, 0);
    f0 = fires;
    repeat (4) step(1, 0, 0, 0);
    chk("refill_req_count", fires - f0, 1);
    // redirect with two requests in flight
    step(1, 1, 1, 32'h300);
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103);
    repeat (10) step(1, 1, 0, 0);
    // redirect colliding with response and pop
    lat_lo = 1;
    lat_hi = 1;
    step(1, 1, 1, 32'h0);
    repeat (5) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h40);
    repeat (4) step(1, 1, 0, 0);
    // faulting fetch at pc 0x8
    err_on = 1'b1;
    err_addr = 32'h8;
    step(1, 1, 1, 32'h0);
    repeat (8) step(1, 1, 0, 0);
    err_on = 1'b0;
    // wraparound at top of address space
    step(1, 1, 1, 32'hFFFF_FFFC);
    repeat (6) step(1, 1, 0, 0);
    // asynchronous reset mid-stream
    @(negedge i_clk);
    #2;
    i_reset = 1'b0;
    i_imem_req_ready = 1'b0;
    i_instr_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    // randomized traffic
    rnd_err = 1'b1;
    lat_lo = 1;
    lat_hi = 4;
    repeat (800) step(1'($urandom % 4 != 0), 1'($urandom % 3 != 0), 1'($urandom % 23 == 0), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
